// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default baud divisor and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int DEFAULT_CLOCKS_PER_BIT = 5208;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter; registered count, full/empty
// derived from it, combinational read of the head entry.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only: stale entries are never read because count gates pops.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes serialised as 8N1 frames, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       TXD,
  output logic       BUSY
);

  localparam int                CNT_W    = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       fifo_data;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             bit_done;
  logic             txd_next;
`ifdef UART_TX_PARITY_EN
  logic             parity;
`endif

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .reset    (RESET),
    .push     (push),
    .push_data(TX_DATA),
    .pop      (pop),
    .pop_data (fifo_data),
    .full     (full),
    .empty    (empty)
  );

  assign TX_READY = !full;
  assign push     = TX_VALID && !full;
  assign bit_done = (bit_cnt == CNT_LAST);
  // Loading the shift register and popping the FIFO are the same event.
  assign pop      = !empty && ((state == IDLE) || ((state == STOP) && bit_done));

  always_comb begin
    txd_next = STOP_BIT;
    case (state)
      START:   txd_next = START_BIT;
      DATA:    txd_next = shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_next = parity;
`endif
      default: txd_next = STOP_BIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      TXD     <= STOP_BIT;
      BUSY    <= 1'b0;
    end else begin
      TXD     <= txd_next;
      BUSY    <= (state != IDLE) || !empty;
      bit_cnt <= (state == IDLE || bit_done) ? '0 : bit_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            shift <= fifo_data;
`ifdef UART_TX_PARITY_EN
            parity <= ^fifo_data;
`endif
            state <= START;
          end
        end
        START: begin
          if (bit_done) begin
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_done) state <= STOP;
        end
        STOP: begin
          if (bit_done) begin
            if (pop) begin
              shift <= fifo_data;
`ifdef UART_TX_PARITY_EN
              parity <= ^fifo_data;
`endif
              state <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed + randomized bench for uart_tx at 16 clocks per bit; frames are decoded
// from TXD and compared against bit patterns built from each pushed byte.
module tb_uart_tx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       CLK;
  logic       RESET;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic       TXD;
  logic       BUSY;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  uart_tx #(
    .CLOCKS_PER_BIT(CPB),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .TX_DATA (TX_DATA),
    .TX_VALID(TX_VALID),
    .TX_READY(TX_READY),
    .TXD     (TXD),
    .BUSY    (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line levels of one frame, index 0 = first bit on the wire.
  function automatic logic [10:0] frame_of(input int d);
    logic [10:0] f;
    int ones;
    f    = '0;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[1+i] = ((d >> i) & 1) != 0;
      ones += (d >> i) & 1;
    end
    if (NB == 11) f[9] = (ones % 2) != 0;
    f[NB-1] = 1'b1;
    return f;
  endfunction

  // Waits (bounded) for a start bit, then samples every cycle of the frame.
  task automatic recv_frame(output logic [10:0] bits, output bit stable, output int start);
    int guard;
    guard  = 0;
    bits   = '0;
    stable = 1'b1;
    start  = -1;
    while (TXD !== 1'b0 && guard < 3000) begin
      tick();
      guard++;
    end
    if (TXD !== 1'b0) return;
    start = cyc;
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < CPB; k++) begin
        if (b != 0 || k != 0) tick();
        if (k == 0) bits[b] = TXD;
        else if (TXD !== bits[b]) stable = 1'b0;
      end
    end
  endtask

  logic [10:0] bits;
  bit          stable;
  int          start;
  int          prev_start;
  int          lows;
  int          n_acc;
  int          acc_at_full;
  int          exp_q[$];

  initial begin
    RESET    = 1'b1;
    TX_DATA  = 8'h00;
    TX_VALID = 1'b0;
    repeat (3) tick();
    chk("reset_txd", TXD, 1);
    chk("reset_ready", TX_READY, 1);
    chk("reset_busy", BUSY, 0);
    RESET = 1'b0;
    lows  = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (TXD !== 1'b1) lows++;
    end
    chk("idle_quiet", lows, 0);
    chk("idle_busy", BUSY, 0);

    // Single byte 0xA5, exact latency and BUSY timing.
    TX_DATA  = 8'hA5;
    TX_VALID = 1'b1;
    tick();
    TX_VALID = 1'b0;
    chk("a5_busy_at_accept", BUSY, 0);
    tick();
    chk("a5_txd_n1", TXD, 1);
    chk("a5_busy_n1", BUSY, 1);
    tick();
    chk("a5_txd_n2", TXD, 0);
    recv_frame(bits, stable, start);
    chk("a5_timeout", start >= 0, 1);
    chk("a5_frame", bits, frame_of(8'hA5));
    chk("a5_stable", stable, 1);
    chk("a5_busy_last_stop", BUSY, 1);
    tick();
    chk("a5_busy_fall", BUSY, 0);
    chk("a5_txd_idle", TXD, 1);

    // Hold TX_VALID over 0x01..0x06: FIFO fills, frames run back-to-back.
    n_acc       = 0;
    acc_at_full = -1;
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          int guard;
          guard    = 0;
          TX_DATA  = 8'(i);
          TX_VALID = 1'b1;
          while (!TX_READY && guard < 1000) begin
            if (acc_at_full < 0) acc_at_full = n_acc;
            tick();
            guard++;
          end
          tick();
          n_acc++;
        end
        TX_VALID = 1'b0;
      end
      begin
        prev_start = -1;
        for (int k = 0; k < 6; k++) begin
          logic [10:0] fb;
          bit          fs;
          int          st;
          recv_frame(fb, fs, st);
          chk("fill_timeout", st >= 0, 1);
          chk("fill_frame", fb, frame_of(k + 1));
          chk("fill_stable", fs, 1);
          if (k > 0) chk("fill_gap", st - prev_start, NB * CPB);
          prev_start = st;
        end
      end
    join
    chk("fill_ready_drop", acc_at_full, DEPTH + 1);
    tick();
    chk("fill_busy_end", BUSY, 0);

    // Random bytes with random spacing, checked in order against a queue.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int guard;
          int d;
          d        = int'($urandom_range(0, 255));
          guard    = 0;
          TX_DATA  = 8'(d);
          TX_VALID = 1'b1;
          while (!TX_READY && guard < 1000) begin
            tick();
            guard++;
          end
          exp_q.push_back(d);
          tick();
          TX_VALID = 1'b0;
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      begin
        for (int k = 0; k < 6; k++) begin
          logic [10:0] fb;
          bit          fs;
          int          st;
          int          e;
          recv_frame(fb, fs, st);
          chk("rand_timeout", st >= 0, 1);
          e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
          chk("rand_frame", fb, frame_of(e));
          chk("rand_stable", fs, 1);
        end
      end
    join
    tick();
    chk("rand_busy_end", BUSY, 0);

    // Reset in the middle of data bit 3 of 0xFF.
    TX_DATA  = 8'hFF;
    TX_VALID = 1'b1;
    tick();
    TX_VALID = 1'b0;
    lows = 0;
    while (TXD !== 1'b0 && lows < 100) begin
      tick();
      lows++;
    end
    chk("rst_start_seen", TXD, 0);
    repeat (4 * CPB + 5) tick();
    chk("rst_bit3_level", TXD, 1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rst_txd", TXD, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_ready", TX_READY, 1);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (TXD !== 1'b1) lows++;
    end
    chk("rst_no_frame", lows, 0);
    chk("rst_busy_after", BUSY, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
